// File: rtl/br_write_arb_if.sv
// Writeback bundle between sources A/B, the write arbiter and the br bank.
// Sources drive the master side; the arbiter sits on the slave side.
interface br_write_arb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          A_Valid;
  logic [AW-1:0] A_Reg;
  logic [DW-1:0] A_Data;
  logic          A_Ready;

  logic          B_Valid;
  logic [AW-1:0] B_Reg;
  logic [DW-1:0] B_Data;
  logic          B_Ready;

  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [1:0]    Pending;

  modport master (
    output A_Valid, A_Reg, A_Data,
    input  A_Ready,
    output B_Valid, B_Reg, B_Data,
    input  B_Ready,
    input  RegWrite, WriteReg, WriteData,
    input  Pending
  );

  modport slave (
    input  A_Valid, A_Reg, A_Data,
    output A_Ready,
    input  B_Valid, B_Reg, B_Data,
    output B_Ready,
    output RegWrite, WriteReg, WriteData,
    output Pending
  );
endinterface

// File: rtl/br_write_arb.sv
// Round-robin arbiter sharing the br write port between two writeback
// sources, each buffered by a one-entry slot with valid/ready handshake.
module br_write_arb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic           clk,
  input logic           reset,
  br_write_arb_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } slot_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic  full_a, full_a_d;
  logic  full_b, full_b_d;
  slot_t slot_a, slot_a_d;
  slot_t slot_b, slot_b_d;
  src_e  last, last_d;

  logic          we_q, we_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] wd_q, wd_d;

  logic grant_a, grant_b;
  logic rdy_a, rdy_b;
  logic acc_a, acc_b;

  // Under contention the source that was not granted last wins.
  always_comb begin
    grant_a = full_a & (~full_b | (last == SRC_B));
    grant_b = full_b & (~full_a | (last == SRC_A));
    rdy_a   = ~full_a | grant_a;
    rdy_b   = ~full_b | grant_b;
    acc_a   = bus.A_Valid & rdy_a;
    acc_b   = bus.B_Valid & rdy_b;
  end

  always_comb begin
    full_a_d = acc_a | (full_a & ~grant_a);
    full_b_d = acc_b | (full_b & ~grant_b);
    slot_a_d = slot_a;
    slot_b_d = slot_b;
    last_d   = last;
    we_d     = 1'b0;
    wr_d     = wr_q;
    wd_d     = wd_q;

    if (acc_a) begin
      slot_a_d = '{rd: bus.A_Reg, data: bus.A_Data};
    end
    if (acc_b) begin
      slot_b_d = '{rd: bus.B_Reg, data: bus.B_Data};
    end

    // The pointer only moves on edges where both slots competed.
    if (full_a & full_b) begin
      last_d = grant_a ? SRC_A : SRC_B;
    end

    // A write to x0 still drains its slot but never enables br.
    unique case (1'b1)
      grant_a: begin
        we_d = |slot_a.rd;
        wr_d = slot_a.rd;
        wd_d = slot_a.data;
      end
      grant_b: begin
        we_d = |slot_b.rd;
        wr_d = slot_b.rd;
        wd_d = slot_b.data;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
      slot_a <= '0;
      slot_b <= '0;
      last   <= SRC_B;
      we_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
    end else begin
      full_a <= full_a_d;
      full_b <= full_b_d;
      slot_a <= slot_a_d;
      slot_b <= slot_b_d;
      last   <= last_d;
      we_q   <= we_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
    end
  end

  assign bus.A_Ready   = rdy_a;
  assign bus.B_Ready   = rdy_b;
  assign bus.RegWrite  = we_q;
  assign bus.WriteReg  = wr_q;
  assign bus.WriteData = wd_q;
  assign bus.Pending   = {full_b, full_a};

endmodule

// File: tb/tb_br_write_arb.sv
// Scoreboard bench for br_write_arb: expected br writes are queued as
// stimulus is driven and popped whenever RegWrite is seen.
module tb_br_write_arb;

  logic clk;
  logic reset;

  br_write_arb_if #(.DW(32), .AW(5)) bus ();

  br_write_arb #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] br_m[32];
  int          n_run;
  int          n_fail;
  int          n_wr;
  int          cyc;
  int          first_cyc;
  int          last_cyc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.A_Valid = 1'b0;
    bus.B_Valid = 1'b0;
  endtask

  task automatic set_a(input logic [4:0] rd, input logic [31:0] d);
    bus.A_Valid = 1'b1;
    bus.A_Reg   = rd;
    bus.A_Data  = d;
  endtask

  task automatic set_b(input logic [4:0] rd, input logic [31:0] d);
    bus.B_Valid = 1'b1;
    bus.B_Reg   = rd;
    bus.B_Data  = d;
  endtask

  // br model: a write seen in a cycle lands at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.RegWrite === 1'b1) begin
      n_wr++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, bus.WriteReg}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_reg", {59'd0, bus.WriteReg}, {59'd0, e.rd});
        chk("write_data", {32'd0, bus.WriteData}, {32'd0, e.data});
      end
      if (bus.WriteReg != 5'd0) br_m[bus.WriteReg] = bus.WriteData;
    end
  end

  initial begin
    int ai;
    int bi;
    int guard;
    logic ra;
    logic rb;
    n_run     = 0;
    n_fail    = 0;
    n_wr      = 0;
    cyc       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < 32; i++) br_m[i] = 32'd0;
    reset       = 1'b1;
    bus.A_Valid = 1'b0;
    bus.A_Reg   = '0;
    bus.A_Data  = '0;
    bus.B_Valid = 1'b0;
    bus.B_Reg   = '0;
    bus.B_Data  = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_regwrite", {63'd0, bus.RegWrite}, 64'd0);
    chk("rst_writereg", {59'd0, bus.WriteReg}, 64'd0);
    chk("rst_writedata", {32'd0, bus.WriteData}, 64'd0);
    chk("rst_pending", {62'd0, bus.Pending}, 64'd0);
    chk("rst_a_ready", {63'd0, bus.A_Ready}, 64'd1);
    chk("rst_b_ready", {63'd0, bus.B_Ready}, 64'd1);
    reset = 1'b0;

    // Single uncontended write
    @(negedge clk);
    set_a(5'd31, 32'hFFFF_FFFF);
    push(5'd31, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    chk("single_pending", {62'd0, bus.Pending}, 64'd1);
    @(negedge clk);
    chk("single_we_hi", {63'd0, bus.RegWrite}, 64'd1);
    @(negedge clk);
    chk("single_we_lo", {63'd0, bus.RegWrite}, 64'd0);
    chk("single_br31", {32'd0, br_m[31]}, 64'hFFFF_FFFF);

    // Contention right after reset: A first
    @(negedge clk);
    set_a(5'd17, 32'd23);
    set_b(5'd11, 32'd47);
    push(5'd17, 32'd23);
    push(5'd11, 32'd47);
    @(negedge clk);
    idle();
    #1;
    chk("cont_pending", {62'd0, bus.Pending}, 64'd3);
    chk("cont_b_stall", {63'd0, bus.B_Ready}, 64'd0);
    @(negedge clk);
    #1;
    chk("cont_b_ready", {63'd0, bus.B_Ready}, 64'd1);
    repeat (2) @(negedge clk);
    chk("cont_drained", {62'd0, bus.Pending}, 64'd0);

    // Same destination with last=A: B issues first, A wins in br
    set_a(5'd1, 32'd10);
    set_b(5'd1, 32'd20);
    push(5'd1, 32'd20);
    push(5'd1, 32'd10);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("samedst_br1", {32'd0, br_m[1]}, 64'd10);

    // Register 0: drains without a br write
    set_a(5'd0, 32'd5);
    @(negedge clk);
    idle();
    chk("x0_pending_set", {62'd0, bus.Pending}, 64'd1);
    @(negedge clk);
    chk("x0_we", {63'd0, bus.RegWrite}, 64'd0);
    chk("x0_pending_clr", {62'd0, bus.Pending}, 64'd0);
    chk("x0_br0", {32'd0, br_m[0]}, 64'd0);

    // Reset mid-stream with both slots full
    set_a(5'd20, 32'd1);
    set_b(5'd21, 32'd2);
    @(posedge clk);
    #2;
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_we", {63'd0, bus.RegWrite}, 64'd0);
    chk("mid_rst_wr", {59'd0, bus.WriteReg}, 64'd0);
    chk("mid_rst_wd", {32'd0, bus.WriteData}, 64'd0);
    chk("mid_rst_pend", {62'd0, bus.Pending}, 64'd0);
    chk("mid_rst_ardy", {63'd0, bus.A_Ready}, 64'd1);
    chk("mid_rst_brdy", {63'd0, bus.B_Ready}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Streaming both sources: strict A,B alternation
    for (int i = 0; i < 4; i++) begin
      push(5'(2 + i), 32'(100 + i));
      push(5'(6 + i), 32'(200 + i));
    end
    n_wr      = 0;
    first_cyc = -1;
    ai        = 0;
    bi        = 0;
    guard     = 0;
    while ((ai < 4 || bi < 4) && guard < 40) begin
      @(negedge clk);
      idle();
      if (ai < 4) set_a(5'(2 + ai), 32'(100 + ai));
      if (bi < 4) set_b(5'(6 + bi), 32'(200 + bi));
      #1;
      ra = bus.A_Ready;
      rb = bus.B_Ready;
      @(posedge clk);
      if (bus.A_Valid && ra) ai++;
      if (bus.B_Valid && rb) bi++;
      guard++;
    end
    chk("stream_timeout", {63'd0, guard >= 40}, 64'd0);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    chk("stream_pulses", 64'(n_wr), 64'd8);
    chk("stream_span", 64'(last_cyc - first_cyc), 64'd7);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
